// File: rtl/pipe_pkg.sv
// Shared pipeline types: register id width and the in-flight slot record.
package pipe_pkg;
    localparam int REG_ID_W = 3;
    localparam int NUM_REGS = 8;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    typedef struct packed {
        logic    valid;
        reg_id_t rd;
        logic    is_load;
    } slot_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input slot_t s);
        rd_onehot = '0;
        if (s.valid) rd_onehot[s.rd] = 1'b1;
    endfunction
endpackage

// File: rtl/scoreboard_slot.sv
// One registered in-flight slot with load/hold/clear and a Rs/Rt compare.
module scoreboard_slot
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    i_clear,
    input  logic    i_load,
    input  slot_t   i_d,
    input  reg_id_t i_rs,
    input  logic    i_rs_valid,
    input  reg_id_t i_rt,
    input  logic    i_rt_valid,
    output slot_t   o_q,
    output logic    o_match
);
    slot_t r_q;
    logic  w_rs_hit;
    logic  w_rt_hit;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign w_rs_hit = i_rs_valid & r_q.valid & (r_q.rd == i_rs);
    assign w_rt_hit = i_rt_valid & r_q.valid & (r_q.rd == i_rt);
    assign o_match  = w_rs_hit | w_rt_hit;
    assign o_q      = r_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard over EX/MEM/WB slots with a saturating stall counter.
// Define HAZARD_FORWARDING_EN to stall only on load-use against the EX slot.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ID_W-1:0] id_rs,
    input  logic [REG_ID_W-1:0] id_rt,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_rs_valid,
    input  logic                id_rt_valid,
    input  logic                id_rd_valid,
    input  logic                id_inst_valid,
    input  logic                id_is_load,
    input  logic                flush,
    input  logic                freeze,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    stall_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t                 w_d [NUM_STAGES];
    slot_t                 w_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] w_match;
    logic                  w_hazard;
    logic [NUM_REGS-1:0]   w_busy;
    logic [CNT_W-1:0]      r_cnt;

    // Slot 0 is EX; a stalled or flushed decode enters as a bubble.
    assign w_d[0] = {id_inst_valid & id_rd_valid & ~stall & ~flush,
                     id_rd, id_is_load};

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
        if (g > 0) begin : g_chain
            assign w_d[g] = w_q[g-1];
        end
        scoreboard_slot u_slot (
            .clk        (clk),
            .i_clear    (rst),
            .i_load     (~freeze),
            .i_d        (w_d[g]),
            .i_rs       (id_rs),
            .i_rs_valid (id_rs_valid),
            .i_rt       (id_rt),
            .i_rt_valid (id_rt_valid),
            .o_q        (w_q[g]),
            .o_match    (w_match[g])
        );
    end

`ifdef HAZARD_FORWARDING_EN
    assign w_hazard = w_match[0] & w_q[0].is_load;
`else
    assign w_hazard = |w_match;
`endif

    assign stall = id_inst_valid & ~flush & w_hazard;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_busy = w_busy | rd_onehot(w_q[i]);
        end
    end

    assign busy_mask = w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (~freeze & stall & (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall_count = r_cnt;
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning the number of in-flight tracking slots: EX, MEM, WB.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have ports id_rs, id_rt and id_rd, each input, 3, the decode-stage register identifiers.
REQ-006 SHALL have ports id_rs_valid, id_rt_valid and id_rd_valid, each input, 1, qualifying the matching identifier.
REQ-007 SHALL have port id_inst_valid, input, 1, meaning decode holds a real instruction and not a bubble.
REQ-008 SHALL have port id_is_load, input, 1, meaning the decode instruction is LD.
REQ-009 SHALL have port flush, input, 1, meaning a taken branch or jump squashes the instruction in decode.
REQ-010 SHALL have port freeze, input, 1, meaning an external memory stall holds the whole pipeline.
REQ-011 SHALL have port stall, output, 1, meaning decode must hold and a bubble is inserted into EX.
REQ-012 SHALL have port busy_mask, output, 8, with bit n set when any valid slot targets register n.
REQ-013 SHALL have port stall_count, output, CNT_W, counting stall cycles and saturating at its maximum.

Function
REQ-014 SHALL keep one slot per stage, each holding {valid, rd[2:0], is_load}.
REQ-015 SHALL, on each clock with freeze=0, shift WB<-MEM and MEM<-EX.
- EX loads {id_inst_valid & id_rd_valid & ~stall & ~flush, id_rd, id_is_load}.
REQ-016 SHALL hold all slots and stall_count unchanged on a clock with freeze=1.
REQ-017 SHALL compute a source match as valid source & valid slot & equal identifiers; Rs and Rt are checked independently.
REQ-018 SHALL drive stall combinationally from the slots and the decode inputs, with zero-cycle latency.
REQ-019 SHALL force stall=0 when id_inst_valid=0 or flush=1; flush has priority over stall.
REQ-020 SHALL raise stall for at most NUM_STAGES consecutive cycles per hazard, because the bubbles drain the matching slot.
REQ-021 SHALL let the youngest slot decide when several slots hold the same rd; the stall lasts until no slot matches.
REQ-022 SHALL increment stall_count on each non-frozen cycle with stall=1, and hold it at 2^CNT_W-1 once there.
REQ-023 SHALL derive busy_mask as the OR of the one-hot decoded rd of the valid slots.

Reset
REQ-024 SHALL, on a clock with rst=1, clear every slot valid bit, rd and is_load, and clear stall_count to 0; rst has priority over freeze and flush.
REQ-025 SHALL present stall=0 and busy_mask=8'h00 in the cycle after reset, with reset usable mid-operation and no residual hazards.

Configuration
REQ-026 SHALL, when macro HAZARD_FORWARDING_EN is defined, stall only on load-use: a source match against the EX slot with is_load=1.
REQ-027 SHALL, when HAZARD_FORWARDING_EN is undefined, stall on a source match against any valid slot (EX, MEM or WB), because there is no register-file bypass.

Structure
REQ-028 SHALL take REG_ID_W=3, NUM_REGS=8 and the slot-record field layout from the shared package pipe_pkg.
REQ-029 SHALL implement one sub-module, scoreboard_slot, instantiated NUM_STAGES times.
- Each instance is a single registered slot with load, hold and clear controls plus a two-port source compare.

Verification
REQ-030 SHALL cover the no-forwarding RAW case: ADD writes r3, then ADDI reads r3 (Rs=3) -> stall=1 for 3 cycles, then 0; stall_count=3.
REQ-031 SHALL cover load-use with HAZARD_FORWARDING_EN: LD r2, then ADD with Rt=2 -> stall=1 for exactly 1 cycle; ADD with Rt=2 after a non-load -> stall=0.
REQ-032 SHALL cover flush with a hazard: hazard present and flush=1 -> stall=0, and EX loads valid=0 on the next edge.
REQ-033 SHALL cover freeze: freeze=1 for 4 cycles during a stall -> slots, busy_mask and stall_count unchanged; the stall resumes afterwards with its remaining length.
REQ-034 SHALL cover reset mid-hazard: rst=1 for 1 cycle with slots targeting r1, r5 and r7 -> busy_mask=8'h00, stall=0, stall_count=0.
REQ-035 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> stall_count holds 15.
